// File: rtl/aes_128_out_collector.sv
// ----------------------------------------------------------------------------
// aes_128_out_collector
//
// Collects ciphertext from a fully pipelined, non-stallable aes_128 core. It
// tracks which core input cycles carried real blocks, captures each matching
// result LATENCY edges later into a block FIFO, and streams the buffered
// blocks out as 32-bit words, most significant word first, over valid/ready.
// Upstream issue is credit-gated so a FIFO slot is always reserved for every
// block in flight.
//
// Ports:
//   clk          in   1    rising-edge clock
//   reset        in   1    asynchronous active-low reset
//   issue_valid  in   1    upstream presents a real block to the core
//   issue_ready  out  1    credit available for an issue
//   core_out     in   128  aes_128 output bus
//   m_data       out  32   ciphertext word (MSW first)
//   m_valid      out  1    m_data valid
//   m_ready      in   1    downstream accepts the word
//   m_last       out  1    marks the 4th word of a block
//   err_drop     out  1    sticky: issue_valid seen without credit
//   blk_count    out  16   completed blocks, saturating
//                          (present only with AES_OUT_BLKCNT_EN)
//
// Optional feature macro: AES_OUT_BLKCNT_EN
// ----------------------------------------------------------------------------
module aes_128_out_collector #(
    parameter int unsigned LATENCY = 21,
    parameter int unsigned DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         issue_valid,
    output logic         issue_ready,
    input  logic [127:0] core_out,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         err_drop
`ifdef AES_OUT_BLKCNT_EN
    ,
    output logic [15:0]  blk_count
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

    logic [LATENCY-1:0] trk_q, trk_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [1:0]         widx_q, widx_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic               err_q, err_d;
    logic [127:0]       mem_q [DEPTH];

    logic               empty, full, accept, push, pop, hs;
    logic [127:0]       head;

    always_comb begin
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head   = mem_q[rd_ptr_q[AW-1:0]];

        issue_ready = (credit_q != '0);
        m_valid     = !empty;
        m_last      = !empty && (widx_q == 2'd3);
        err_drop    = err_q;

        // Held at zero while empty so the idle bus never shows stale storage.
        m_data = '0;
        if (!empty) begin
            case (widx_q)
                2'd0:    m_data = head[127:96];
                2'd1:    m_data = head[95:64];
                2'd2:    m_data = head[63:32];
                default: m_data = head[31:0];
            endcase
        end

        accept = issue_valid && issue_ready;
        hs     = m_valid && m_ready;
        pop    = hs && (widx_q == 2'd3);
        // Credit reservation guarantees space; the full guard only protects
        // the FIFO if upstream ever misbehaves around reset.
        push   = trk_q[LATENCY-1] && !full;
    end

    always_comb begin
        trk_d    = {trk_q[LATENCY-2:0], accept};
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        widx_d   = widx_q;
        credit_d = credit_q;
        err_d    = err_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (hs)   widx_d   = widx_q + 2'd1;

        // Accept and block completion on the same edge cancel out.
        if (accept && !pop)
            credit_d = credit_q - CW'(1);
        else if (pop && !accept)
            credit_d = credit_q + CW'(1);

        if (issue_valid && !issue_ready) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            widx_q   <= '0;
            credit_q <= CREDIT_MAX;
            err_q    <= 1'b0;
        end else begin
            trk_q    <= trk_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            widx_q   <= widx_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    // Block storage needs no reset: contents are only visible when non-empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= core_out;
    end

`ifdef AES_OUT_BLKCNT_EN
    logic [15:0] blk_q, blk_d;

    always_comb begin
        blk_d = blk_q;
        if (pop && (blk_q != '1)) blk_d = blk_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) blk_q <= '0;
        else        blk_q <= blk_d;
    end

    assign blk_count = blk_q;
`endif

endmodule

// File: tb/tb_aes_128_out_collector.sv
// ----------------------------------------------------------------------------
// tb_aes_128_out_collector
//
// Self-checking bench for aes_128_out_collector (LATENCY=21, DEPTH=4). The
// aes_128 core is stood in for by a 21-stage delay line followed by a fixed
// XOR, which has the same timing as the real pipeline. Expected outputs come
// from a transaction-level model: a queue of issued blocks with the edge at
// which each becomes available, a credit count and a word position.
// ----------------------------------------------------------------------------
module tb_aes_128_out_collector;

    localparam int unsigned LAT = 21;
    localparam int unsigned DEP = 4;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         reset;
    logic         issue_valid;
    logic         issue_ready;
    logic [127:0] core_in;
    logic [127:0] core_out;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         err_drop;
    logic [15:0]  blk_count;
    logic [127:0] pipe [LAT];

    always #5 clk = ~clk;

    // Stand-in core: samples its input every edge, result after LAT edges.
    always @(posedge clk) begin
        pipe[0] <= core_in;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LAT-1] ^ KEY;

    aes_128_out_collector #(
        .LATENCY (LAT),
        .DEPTH   (DEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .core_out    (core_out),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .err_drop    (err_drop)
`ifdef AES_OUT_BLKCNT_EN
        ,
        .blk_count   (blk_count)
`endif
    );

`ifndef AES_OUT_BLKCNT_EN
    assign blk_count = '0;
`endif

    typedef struct {
        logic [127:0] data;
        int unsigned  cap;
    } blk_t;

    blk_t        q[$];
    int unsigned credit;
    int unsigned widx;
    int unsigned edge_cnt;
    int unsigned blk_model;
    bit          err_model;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        credit    = DEP;
        widx      = 0;
        blk_model = 0;
        err_model = 1'b0;
    endtask

    function automatic bit exp_mv();
        return (q.size() > 0) && (q[0].cap <= edge_cnt);
    endfunction

    task automatic check_all();
        logic [127:0] d;
        logic [31:0]  w;
        bit           mv;
        mv = exp_mv();
        chk("issue_ready", issue_ready, credit != 0);
        chk("m_valid", m_valid, mv);
        if (mv) begin
            d = q[0].data;
            w = d[127 - 32*widx -: 32];
            chk("m_data", m_data, w);
            chk("m_last", m_last, widx == 3);
        end
        chk("err_drop", err_drop, err_model);
`ifdef AES_OUT_BLKCNT_EN
        chk("blk_count", blk_count, blk_model);
`endif
    endtask

    // One clock: inputs already set (issue_valid, m_ready); core_in randomised.
    task automatic step();
        bit hs, acc, drop;
        core_in = {$urandom, $urandom, $urandom, $urandom};
        hs   = exp_mv() && m_ready;
        acc  = issue_valid && (credit != 0);
        drop = issue_valid && (credit == 0);
        @(posedge clk);
        edge_cnt++;
        if (hs) begin
            if (widx == 3) begin
                void'(q.pop_front());
                credit++;
                widx = 0;
                if (blk_model < 16'hFFFF) blk_model++;
            end else begin
                widx++;
            end
        end
        if (acc) begin
            q.push_back('{data: core_in ^ KEY, cap: edge_cnt + LAT});
            credit--;
        end
        if (drop) err_model = 1'b1;
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // Issue n blocks as credit allows, bounded by a cycle budget.
    task automatic issue_n(input int unsigned n, input int unsigned budget);
        int unsigned done = 0;
        for (int unsigned i = 0; i < budget && done < n; i++) begin
            issue_valid = (credit != 0);
            if (issue_valid) done++;
            step();
        end
        issue_valid = 1'b0;
        chk("issue_budget", done, n);
    endtask

    initial begin
        reset       = 1'b0;
        issue_valid = 1'b0;
        m_ready     = 1'b0;
        core_in     = '0;
        edge_cnt    = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_err_drop", err_drop, 1'b0);
`ifdef AES_OUT_BLKCNT_EN
        chk("rst_blk_count", blk_count, 16'h0);
`endif
        reset = 1'b1;

        // Single block, downstream always ready; exact capture latency is
        // checked through m_valid on every cycle.
        m_ready = 1'b1;
        issue_n(1, 4);
        run(30);

        // Five back-to-back issues: the fifth waits for returned credit.
        issue_n(5, 200);
        run(40);

        // Four blocks stalled for 60 cycles, then a full-rate drain.
        m_ready = 1'b0;
        issue_n(4, 20);
        run(60);
        chk("stall_issue_ready", issue_ready, 1'b0);
        chk("stall_m_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        run(25);

        // Random traffic with random backpressure, never issuing without credit.
        for (int unsigned i = 0; i < 400; i++) begin
            issue_valid = (credit != 0) && ($urandom_range(0, 1) == 1);
            m_ready     = ($urandom_range(0, 3) != 0);
            step();
        end
        issue_valid = 1'b0;
        m_ready     = 1'b1;
        run(40);

        // Dropped issue while out of credit: sticky error, nothing extra delivered.
        m_ready = 1'b0;
        issue_n(4, 20);
        run(3);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        chk("drop_err", err_drop, 1'b1);
        run(30);
        m_ready = 1'b1;
        run(60);

        // Reset with one block buffered and two in flight.
        m_ready = 1'b0;
        issue_n(1, 4);
        run(22);
        issue_n(2, 4);
        run(5);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_m_valid", m_valid, 1'b0);
        chk("arst_m_last", m_last, 1'b0);
        chk("arst_issue_ready", issue_ready, 1'b1);
        chk("arst_err_drop", err_drop, 1'b0);
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        reset   = 1'b1;
        m_ready = 1'b1;
        check_all();
        run(40);
        issue_n(1, 4);
        run(30);
        chk("end_m_valid", m_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
